// File: rtl/mips_pkg.sv
// Shared MIPS execute-stage definitions: ALU control codes and the
// sequential multiplier's state encoding.
package mips_pkg;

  // ALU control codes understood by the combinational 32-bit ALU.
  localparam logic [2:0] ALU_ADD_CTR = 3'b010;
  localparam logic [2:0] ALU_SUB_CTR = 3'b110;
  localparam logic [2:0] ALU_SLT_CTR = 3'b100;

  // Multiplier iteration counter width: one count per multiplier bit.
  localparam int MUL_CNT_W = 5;

  // Sequential multiplier FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    DONE = 2'd2
  } mul_state_e;

endpackage : mips_pkg

// File: rtl/alu_mul_seq_carry_recover.sv
// Recovers the carry-out of an unsigned add performed on a carry-less ALU,
// using only the MSBs of both operands and of the sum.
module carry_recover (
  input  logic a_msb_i,
  input  logic b_msb_i,
  input  logic sum_msb_i,
  output logic carry_o
);

  // Carry out of the top bit: both MSBs set, or one set and the sum MSB
  // cleared (meaning a carry came in and propagated out).
  assign carry_o = (a_msb_i & b_msb_i) | ((a_msb_i | b_msb_i) & ~sum_msb_i);

endmodule : carry_recover

// File: rtl/alu_mul_seq.sv
// Sequential unsigned 32x32->64 shift-add multiplier. Borrows the
// execute-stage ALU for every partial-sum addition, one multiplier bit
// per cycle, and presents the product on prod_hi/prod_lo.
module alu_mul_seq
  import mips_pkg::*;
#(
  parameter int         WIDTH       = 32,
  parameter logic [2:0] ALU_ADD_CTR = mips_pkg::ALU_ADD_CTR
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] prod_hi,
  output logic [WIDTH-1:0] prod_lo,
  output logic [WIDTH-1:0] alu_src1,
  output logic [WIDTH-1:0] alu_src2,
  output logic [2:0]       alu_ctr,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             zero_bit
);

  mul_state_e             state_q, state_d;
  logic [WIDTH-1:0]       mcand_q, mcand_d;
  logic [WIDTH-1:0]       prod_hi_q, prod_hi_d;
  logic [WIDTH-1:0]       prod_lo_q, prod_lo_d;
  logic [MUL_CNT_W-1:0]   cnt_q, cnt_d;
  logic                   prod_zero_q;
  logic                   add_carry;

  // Carry out of prod_hi + mcand, rebuilt from MSBs since the ALU has no carry.
  carry_recover u_carry_recover (
    .a_msb_i   (prod_hi_q[WIDTH-1]),
    .b_msb_i   (mcand_q[WIDTH-1]),
    .sum_msb_i (alu_result[WIDTH-1]),
    .carry_o   (add_carry)
  );

  // ALU operand drive: partial-sum add while stepping, quiet zeros otherwise.
  always_comb begin
    alu_ctr  = ALU_ADD_CTR;
    alu_src1 = '0;
    alu_src2 = '0;
    if (state_q == STEP) begin
      alu_src1 = prod_hi_q;
      alu_src2 = mcand_q;
    end
  end

  // Next-state and datapath update for the shift-add iteration.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    state_d   = state_q;
    mcand_d   = mcand_q;
    prod_hi_d = prod_hi_q;
    prod_lo_d = prod_lo_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d   = op_a;
          prod_hi_d = '0;
          prod_lo_d = op_b;
          cnt_d     = '0;
          state_d   = STEP;
        end
      end
      STEP: begin
        if (prod_lo_q[0]) begin
          {prod_hi_d, prod_lo_d} = {add_carry, alu_result, prod_lo_q[WIDTH-1:1]};
        end else begin
          {prod_hi_d, prod_lo_d} = {1'b0, prod_hi_q, prod_lo_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + MUL_CNT_W'(1);
        if (cnt_q == {MUL_CNT_W{1'b1}}) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // Result is already in place; start is deliberately ignored here.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q     <= IDLE;
      mcand_q     <= '0;
      prod_hi_q   <= '0;
      prod_lo_q   <= '0;
      cnt_q       <= '0;
      prod_zero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      prod_hi_q <= prod_hi_d;
      prod_lo_q <= prod_lo_d;
      cnt_q     <= cnt_d;
      if (state_q == STEP) begin
        prod_zero_q <= zero_bit;
      end
    end
  end

  assign busy    = (state_q == STEP);
  assign done    = (state_q == DONE);
  assign prod_hi = prod_hi_q;
  assign prod_lo = prod_lo_q;

endmodule : alu_mul_seq
